// File: rtl/zap_mem_align_buffer.sv
// zap_mem_align_buffer: aligns/extends load data, passes non-load results, buffers in a DEPTH-entry FIFO.
// Latency: a beat pushed into an empty buffer is presented on o_valid/o_data the next cycle.
// Backpressure: o_ready depends only on registered occupancy; a full buffer holds beats until i_ready.
//
// Ports:
//   i_clk, i_reset (sync, active-high), i_clear (flush, wins over push/pop)
//   upstream:   i_valid/o_ready, i_load, i_addr, i_size, i_signed, i_rd_data,
//               i_pass_data, i_dest_index, i_fault
//   downstream: o_valid/i_ready, o_data, o_dest_index, o_load, o_fault, o_count
//
// Optional build macro: ZAP_MEM_ALIGN_BIG_ENDIAN_EN reverses the byte lanes of
// i_rd_data before lane selection (BE-32 load view). i_pass_data is never reversed.
module zap_mem_align_buffer #(
  parameter int DATA_WDT = 32,
  parameter int DEPTH    = 2,
  parameter int IDX_WDT  = 6
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_clear,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic                          i_load,
  input  logic [$clog2(DATA_WDT/8)-1:0] i_addr,
  input  logic [1:0]                    i_size,
  input  logic                          i_signed,
  input  logic [DATA_WDT-1:0]           i_rd_data,
  input  logic [DATA_WDT-1:0]           i_pass_data,
  input  logic [IDX_WDT-1:0]            i_dest_index,
  input  logic [1:0]                    i_fault,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [DATA_WDT-1:0]           o_data,
  output logic [IDX_WDT-1:0]            o_dest_index,
  output logic                          o_load,
  output logic [1:0]                    o_fault,
  output logic [$clog2(DEPTH):0]        o_count
);

  localparam int NB = DATA_WDT / 8;
  localparam int AW = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_PART  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // ---------------------------------------------------------------------------
  // Load alignment (computed at push, stored final)
  // ---------------------------------------------------------------------------
  logic [DATA_WDT-1:0] rd_view;

`ifdef ZAP_MEM_ALIGN_BIG_ENDIAN_EN
  always_comb begin
    rd_view = '0;
    for (int i = 0; i < NB; i++) begin
      rd_view[8*i +: 8] = i_rd_data[8*(NB-1-i) +: 8];
    end
  end
`else
  assign rd_view = i_rd_data;
`endif

  logic [7:0]          byte_v;
  logic [15:0]         half_v;
  logic [31:0]         word_v;
  logic [31:0]         word_rot;
  logic [DATA_WDT-1:0] aligned;

  assign byte_v = rd_view[{i_addr, 3'b000} +: 8];
  // Half lane comes from the upper address bits; i_addr[0] is ignored.
  assign half_v = rd_view[{i_addr[AW-1:1], 4'b0000} +: 16];

  if (DATA_WDT == 64) begin : g_word64
    assign word_v = i_addr[AW-1] ? rd_view[63:32] : rd_view[31:0];
  end else begin : g_word32
    assign word_v = rd_view[31:0];
  end

  // Unaligned word loads rotate right by the byte offset (ARM-style).
  always_comb begin
    word_rot = word_v;
    case (i_addr[1:0])
      2'd1:    word_rot = {word_v[7:0],  word_v[31:8]};
      2'd2:    word_rot = {word_v[15:0], word_v[31:16]};
      2'd3:    word_rot = {word_v[23:0], word_v[31:24]};
      default: word_rot = word_v;
    endcase
  end

  always_comb begin
    aligned = '0;
    if (!i_load) begin
      aligned = i_pass_data;
    end else begin
      case (i_size)
        2'd0:    aligned = {{(DATA_WDT-8){i_signed & byte_v[7]}}, byte_v};
        2'd1:    aligned = {{(DATA_WDT-16){i_signed & half_v[15]}}, half_v};
        2'd2:    aligned[31:0] = word_rot;
        default: begin
          // Doubleword only exists on a 64-bit path; a 32-bit path treats it as word.
          if (DATA_WDT == 64) aligned = rd_view;
          else                aligned[31:0] = word_rot;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic          push, pop;

  assign o_ready = (state_q != ST_FULL);
  assign o_valid = (state_q != ST_EMPTY);
  assign push    = i_valid & o_ready;
  assign pop     = o_valid & i_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    // State is a registered decode of the next occupancy so o_ready/o_valid
    // come straight from flops.
    if (count_d == '0)          state_d = ST_EMPTY;
    else if (count_d == FULL_CNT) state_d = ST_FULL;
    else                        state_d = ST_PART;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage (not reset; head fields are don't-care while o_valid=0)
  // ---------------------------------------------------------------------------
  logic [DATA_WDT-1:0] data_mem_q  [DEPTH];
  logic [IDX_WDT-1:0]  idx_mem_q   [DEPTH];
  logic                load_mem_q  [DEPTH];
  logic [1:0]          fault_mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (push && !i_clear) begin
      data_mem_q[wr_ptr_q]  <= aligned;
      idx_mem_q[wr_ptr_q]   <= i_dest_index;
      load_mem_q[wr_ptr_q]  <= i_load;
      fault_mem_q[wr_ptr_q] <= i_fault;
    end
  end

  assign o_data       = data_mem_q[rd_ptr_q];
  assign o_dest_index = idx_mem_q[rd_ptr_q];
  assign o_load       = load_mem_q[rd_ptr_q];
  assign o_fault      = fault_mem_q[rd_ptr_q];
  assign o_count      = count_q;

endmodule

// File: tb/tb_zap_mem_align_buffer.sv
// Scoreboard bench for zap_mem_align_buffer: a 32-bit/DEPTH=2 instance and a
// 64-bit/DEPTH=4 instance. Stimulus tasks queue hand-computed results; per-instance
// monitors pop and compare whenever the DUT hands off a head entry.
module tb_zap_mem_align_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

`ifdef ZAP_MEM_ALIGN_BIG_ENDIAN_EN
  localparam bit BE = 1'b1;
`else
  localparam bit BE = 1'b0;
`endif

  typedef struct {
    logic [63:0] data;
    logic [5:0]  idx;
    logic        ld;
    logic [1:0]  flt;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int n_vec = 0;
  int n_err = 0;

  // ---------------- instance A: 32-bit, DEPTH 2 ----------------
  logic        a_clr, a_vld, a_ordy, a_ld, a_sgn, a_ovld, a_irdy, a_old;
  logic [1:0]  a_addr, a_size, a_flt, a_oflt, a_cnt;
  logic [31:0] a_rd, a_pass, a_odata;
  logic [5:0]  a_idx, a_oidx;

  zap_mem_align_buffer #(.DATA_WDT(32), .DEPTH(2), .IDX_WDT(6)) u_a (
    .i_clk(clk), .i_reset(rst), .i_clear(a_clr), .i_valid(a_vld), .o_ready(a_ordy),
    .i_load(a_ld), .i_addr(a_addr), .i_size(a_size), .i_signed(a_sgn),
    .i_rd_data(a_rd), .i_pass_data(a_pass), .i_dest_index(a_idx), .i_fault(a_flt),
    .o_valid(a_ovld), .i_ready(a_irdy), .o_data(a_odata), .o_dest_index(a_oidx),
    .o_load(a_old), .o_fault(a_oflt), .o_count(a_cnt)
  );

  // ---------------- instance B: 64-bit, DEPTH 4 ----------------
  logic        b_clr, b_vld, b_ordy, b_ld, b_sgn, b_ovld, b_irdy, b_old;
  logic [2:0]  b_addr, b_cnt;
  logic [1:0]  b_size, b_flt, b_oflt;
  logic [63:0] b_rd, b_pass, b_odata;
  logic [5:0]  b_idx, b_oidx;

  zap_mem_align_buffer #(.DATA_WDT(64), .DEPTH(4), .IDX_WDT(6)) u_b (
    .i_clk(clk), .i_reset(rst), .i_clear(b_clr), .i_valid(b_vld), .o_ready(b_ordy),
    .i_load(b_ld), .i_addr(b_addr), .i_size(b_size), .i_signed(b_sgn),
    .i_rd_data(b_rd), .i_pass_data(b_pass), .i_dest_index(b_idx), .i_fault(b_flt),
    .o_valid(b_ovld), .i_ready(b_irdy), .o_data(b_odata), .o_dest_index(b_oidx),
    .o_load(b_old), .o_fault(b_oflt), .o_count(b_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst && a_ovld && a_irdy && !a_clr) begin
      if (q_a.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL a_unexpected: got output data 0x%0h, required no output", a_odata);
      end else begin
        ea = q_a.pop_front();
        chk("a_data",  {32'h0, a_odata}, ea.data);
        chk("a_idx",   {58'h0, a_oidx},  {58'h0, ea.idx});
        chk("a_load",  {63'h0, a_old},   {63'h0, ea.ld});
        chk("a_fault", {62'h0, a_oflt},  {62'h0, ea.flt});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_ovld && b_irdy && !b_clr) begin
      if (q_b.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL b_unexpected: got output data 0x%0h, required no output", b_odata);
      end else begin
        eb = q_b.pop_front();
        chk("b_data",  b_odata,         eb.data);
        chk("b_idx",   {58'h0, b_oidx}, {58'h0, eb.idx});
        chk("b_load",  {63'h0, b_old},  {63'h0, eb.ld});
        chk("b_fault", {62'h0, b_oflt}, {62'h0, eb.flt});
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic a_beat(input logic ld, input logic [1:0] addr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] rd, input logic [31:0] pass,
                        input logic [5:0] idx, input logic [1:0] flt, input logic [31:0] exp_d);
    int n;
    exp_t e;
    a_vld = 1'b1; a_ld = ld; a_addr = addr; a_size = sz; a_sgn = sg;
    a_rd = rd; a_pass = pass; a_idx = idx; a_flt = flt;
    @(negedge clk);
    n = 0;
    while (!a_ordy && n < 50) begin @(negedge clk); n++; end
    if (!a_ordy) begin
      n_vec++; n_err++;
      $display("FAIL a_push_timeout: o_ready=0 for 50 cycles, required 1");
    end else begin
      e.data = {32'h0, exp_d}; e.idx = idx; e.ld = ld; e.flt = flt;
      q_a.push_back(e);
    end
    @(posedge clk); #1;
    a_vld = 1'b0;
  endtask

  task automatic b_beat(input logic ld, input logic [2:0] addr, input logic [1:0] sz,
                        input logic sg, input logic [63:0] rd, input logic [63:0] pass,
                        input logic [5:0] idx, input logic [1:0] flt, input logic [63:0] exp_d);
    int n;
    exp_t e;
    b_vld = 1'b1; b_ld = ld; b_addr = addr; b_size = sz; b_sgn = sg;
    b_rd = rd; b_pass = pass; b_idx = idx; b_flt = flt;
    @(negedge clk);
    n = 0;
    while (!b_ordy && n < 50) begin @(negedge clk); n++; end
    if (!b_ordy) begin
      n_vec++; n_err++;
      $display("FAIL b_push_timeout: o_ready=0 for 50 cycles, required 1");
    end else begin
      e.data = exp_d; e.idx = idx; e.ld = ld; e.flt = flt;
      q_b.push_back(e);
    end
    @(posedge clk); #1;
    b_vld = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || a_ovld || b_ovld) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    n_vec++;
    if (n >= 100) begin
      n_err++;
      $display("FAIL %s: %0d/%0d entries still pending, required 0", nm, q_a.size(), q_b.size());
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    a_clr = 0; a_vld = 0; a_ld = 0; a_addr = 0; a_size = 0; a_sgn = 0;
    a_rd = 0; a_pass = 0; a_idx = 0; a_flt = 0; a_irdy = 1;
    b_clr = 0; b_vld = 0; b_ld = 0; b_addr = 0; b_size = 0; b_sgn = 0;
    b_rd = 0; b_pass = 0; b_idx = 0; b_flt = 0; b_irdy = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    chk("a_rst_valid", {63'h0, a_ovld}, 64'd0);
    chk("a_rst_ready", {63'h0, a_ordy}, 64'd1);
    chk("a_rst_count", {62'h0, a_cnt},  64'd0);
    chk("b_rst_valid", {63'h0, b_ovld}, 64'd0);
    chk("b_rst_ready", {63'h0, b_ordy}, 64'd1);
    chk("b_rst_count", {61'h0, b_cnt},  64'd0);

    // Signed byte, lane 2, and one-cycle latency into an empty buffer
    a_beat(1, 2'd2, 2'd0, 1, 32'h1285_3456, 32'h0, 6'd1, 2'd0, BE ? 32'h0000_0034 : 32'hFFFF_FF85);
    chk("a_lat_valid", {63'h0, a_ovld}, 64'd1);
    chk("a_lat_count", {62'h0, a_cnt},  64'd1);

    // Rotated word, then a non-load whose size/signed/addr must be ignored
    a_beat(1, 2'd1, 2'd2, 0, 32'hAABB_CCDD, 32'h0, 6'd2, 2'd1, BE ? 32'hAADD_CCBB : 32'hDDAA_BBCC);
    a_beat(0, 2'd3, 2'd1, 1, 32'hFFFF_FFFF, 32'hCAFE_F00D, 6'd3, 2'd2, 32'hCAFE_F00D);
    // Signed half at addr 3 (addr[0] ignored)
    a_beat(1, 2'd3, 2'd1, 1, 32'hF00D_1234, 32'h0, 6'd4, 2'd3, BE ? 32'h0000_3412 : 32'hFFFF_F00D);
    // Size 3 on a 32-bit path behaves as word
    a_beat(1, 2'd2, 2'd3, 0, 32'h1122_3344, 32'h0, 6'd5, 2'd0, BE ? 32'h2211_4433 : 32'h3344_1122);
    // Unsigned byte lane 0 (endianness-sensitive)
    a_beat(1, 2'd0, 2'd0, 0, 32'h1122_3344, 32'h0, 6'd6, 2'd1, BE ? 32'h0000_0011 : 32'h0000_0044);

    // 64-bit path
    b_beat(1, 3'd6, 2'd1, 0, 64'h8001_0000_0000_0000, 64'h0, 6'd10, 2'd0,
           BE ? 64'h0 : 64'h0000_0000_0000_8001);
    b_beat(1, 3'd0, 2'd3, 0, 64'h0123_4567_89AB_CDEF, 64'h0, 6'd11, 2'd1,
           BE ? 64'hEFCD_AB89_6745_2301 : 64'h0123_4567_89AB_CDEF);
    b_beat(1, 3'd5, 2'd2, 1, 64'h1122_3344_5566_7788, 64'h0, 6'd12, 2'd2,
           BE ? 64'h0000_0000_5588_7766 : 64'h0000_0000_4411_2233);
    b_beat(1, 3'd7, 2'd0, 1, 64'h8000_0000_0000_0000, 64'h0, 6'd13, 2'd3,
           BE ? 64'h0 : 64'hFFFF_FFFF_FFFF_FF80);
    b_beat(0, 3'd2, 2'd0, 1, 64'h0, 64'hDEAD_BEEF_0123_4567, 6'd14, 2'd0, 64'hDEAD_BEEF_0123_4567);
    wait_drain("drain_align");

    // Backpressure: fill, third beat stalls, release, simultaneous push+pop
    a_irdy = 1'b0;
    a_beat(0, 2'd0, 2'd0, 0, 32'h0, 32'h0000_0100, 6'd20, 2'd0, 32'h0000_0100);
    a_beat(0, 2'd0, 2'd0, 0, 32'h0, 32'h0000_0200, 6'd21, 2'd1, 32'h0000_0200);
    chk("a_full_ready", {63'h0, a_ordy}, 64'd0);
    chk("a_full_count", {62'h0, a_cnt},  64'd2);
    fork
      a_beat(0, 2'd0, 2'd0, 0, 32'h0, 32'h0000_0300, 6'd22, 2'd2, 32'h0000_0300);
      begin
        repeat (2) @(posedge clk);
        #1;
        chk("a_stall_count", {62'h0, a_cnt},  64'd2);
        chk("a_stall_ready", {63'h0, a_ordy}, 64'd0);
        a_irdy = 1'b1;
      end
    join
    chk("a_pushpop_count", {62'h0, a_cnt}, 64'd1);
    wait_drain("drain_bp");

    // Clear while full with a concurrent beat: everything is discarded
    a_irdy = 1'b0;
    a_beat(0, 2'd0, 2'd0, 0, 32'h0, 32'h0000_0400, 6'd30, 2'd0, 32'h0000_0400);
    a_beat(0, 2'd0, 2'd0, 0, 32'h0, 32'h0000_0500, 6'd31, 2'd0, 32'h0000_0500);
    chk("a_pre_clr_count", {62'h0, a_cnt}, 64'd2);
    a_clr = 1'b1; a_vld = 1'b1; a_ld = 1'b0; a_pass = 32'h0000_0600; a_idx = 6'd32;
    @(posedge clk); #1;
    a_clr = 1'b0; a_vld = 1'b0;
    q_a.delete();
    chk("a_clr_valid", {63'h0, a_ovld}, 64'd0);
    chk("a_clr_count", {62'h0, a_cnt},  64'd0);
    chk("a_clr_ready", {63'h0, a_ordy}, 64'd1);
    a_irdy = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("a_post_clr_valid", {63'h0, a_ovld}, 64'd0);

    // Buffer still works after the flush
    a_beat(0, 2'd0, 2'd0, 0, 32'h0, 32'h0000_0700, 6'd33, 2'd3, 32'h0000_0700);
    wait_drain("drain_final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
